mic_sample_conditioner: RTL and testbench

Conditions raw 24-bit signed microphone samples between the I2S capture stage and the sample RAM write port. Removes DC offset with a first-order leaky integrator, then decimates by 2^DECIM_LOG2 using boxcar averaging. Emits 32-bit sign-extended words on a valid/ready handshake that feeds the RAM write side.

---
 rtl/mic_sample_conditioner.sv | 99 +++++++++
 tb/tb_mic_sample_conditioner.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mic_sample_conditioner.sv
// Microphone sample conditioner: leaky-integrator DC removal, then boxcar decimation
// by 2^DECIM_LOG2, presented on a registered valid/ready output with drop counting.
module mic_sample_conditioner #(
  parameter int DECIM_LOG2 = 2,
  parameter int DC_SHIFT   = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [23:0] sample_i,
  input  logic        sample_valid_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [23:0] dc_estimate_o,
  output logic [15:0] drop_count_o
);

  localparam int AW = 26 + DC_SHIFT;
  localparam int SW = 24 + DECIM_LOG2;
  localparam int PW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'((1 << DECIM_LOG2) - 1);

  logic signed [AW-1:0] dc_acc;
  logic signed [24:0]   dc;
  logic signed [24:0]   diff;
  logic signed [23:0]   diff_sat;
  logic signed [23:0]   hp_q;
  logic                 hp_valid_q;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] sum_next;
  logic [PW-1:0]        phase;
  logic                 cand_valid;
  logic signed [23:0]   cand;

  assign dc   = 25'(dc_acc >>> DC_SHIFT);
  assign diff = $signed({sample_i[23], sample_i}) - dc;

  always_comb begin
    diff_sat = diff[23:0];
    if (diff[24] != diff[23]) begin
      diff_sat = diff[24] ? 24'sh800000 : 24'sh7FFFFF;
    end
  end

  // The estimator integrates the raw difference so saturation never biases the DC track.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dc_acc        <= '0;
      hp_q          <= '0;
      hp_valid_q    <= 1'b0;
      dc_estimate_o <= '0;
    end else begin
      hp_valid_q    <= sample_valid_i;
      dc_estimate_o <= dc[23:0];
      if (sample_valid_i) begin
        dc_acc <= dc_acc + AW'(diff);
        hp_q   <= diff_sat;
      end
    end
  end

  assign sum_next   = sum + SW'(hp_q);
  assign cand       = 24'(sum_next >>> DECIM_LOG2);
  assign cand_valid = hp_valid_q && (phase == LAST_PHASE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum   <= '0;
      phase <= '0;
    end else if (hp_valid_q) begin
      if (phase == LAST_PHASE) begin
        sum   <= '0;
        phase <= '0;
      end else begin
        sum   <= sum_next;
        phase <= phase + PW'(1);
      end
    end
  end

  // A held word is never overwritten; a candidate that cannot land is counted and lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      drop_count_o <= '0;
    end else if (cand_valid) begin
      if (!valid_o || ready_i) begin
        data_o  <= 32'(cand);
        valid_o <= 1'b1;
      end else if (drop_count_o != 16'hFFFF) begin
        drop_count_o <= drop_count_o + 16'd1;
      end
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mic_sample_conditioner.sv
// Scoreboard bench for mic_sample_conditioner: directed vectors push expected words,
// a negedge monitor pops and compares on every accepted output.
module tb_mic_sample_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [23:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] data;
  logic        valid;
  logic [23:0] dc_est;
  logic [15:0] drops;

  logic        rst_sat_n = 1'b0;
  logic [23:0] s_sample = '0;
  logic        s_valid_in = 1'b0;
  logic        s_ready = 1'b0;
  logic [31:0] s_data;
  logic        s_valid;
  logic [23:0] s_dc_est;
  logic [15:0] s_drops;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  bit bypass = 1'b0;

  mic_sample_conditioner #(.DECIM_LOG2(2), .DC_SHIFT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sample_i(sample), .sample_valid_i(sample_valid),
    .data_o(data), .valid_o(valid), .ready_i(ready),
    .dc_estimate_o(dc_est), .drop_count_o(drops)
  );

  // Pass-through instance: one candidate per strobe makes drop saturation reachable quickly.
  mic_sample_conditioner #(.DECIM_LOG2(0), .DC_SHIFT(4)) u_sat (
    .clk_i(clk), .rst_ni(rst_sat_n), .sample_i(s_sample), .sample_valid_i(s_valid_in),
    .data_o(s_data), .valid_o(s_valid), .ready_i(s_ready),
    .dc_estimate_o(s_dc_est), .drop_count_o(s_drops)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name,
               $signed(act), act, $signed(exp), exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (rst_n && valid && ready && !bypass) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got word 0x%0h with no word expected", data);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", data, e);
      end
    end
  end

  task automatic drive(input logic [23:0] v, input logic en);
    sample       = v;
    sample_valid = en;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(24'd0, 1'b0);
  endtask

  task automatic do_reset;
    sample_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete();
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic main_seq;
    // post-reset state and first-group latency
    do_reset();
    check("rst_data", data, 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_dc", 32'(dc_est), 32'd0);
    check("rst_drops", 32'(drops), 32'd0);
    exp_q.push_back(32'd0);
    repeat (4) drive(24'd0, 1'b1);
    check("lat_n1_valid", 32'(valid), 32'd0);
    idle(1);
    check("lat_n2_valid", 32'(valid), 32'd1);
    idle(3);

    // DC step
    do_reset();
    exp_q.push_back(32'd910);
    repeat (4) drive(24'd1000, 1'b1);
    check("dc_after_3", 32'(dc_est), 32'd176);
    idle(1);
    check("dc_after_4", 32'(dc_est), 32'd227);
    idle(3);
    bypass = 1'b1;
    repeat (2000) drive(24'd1000, 1'b1);
    idle(4);
    bypass = 1'b0;
    check("dc_settled_data", data, 32'd0);
    check("dc_settled_est", 32'(dc_est), 32'd1000);

    // saturation: second hp clips to +max, group average -15872
    do_reset();
    exp_q.push_back(32'hFFFF_C200);
    drive(24'h800000, 1'b1);
    drive(24'h7FFFFF, 1'b1);
    drive(24'd0, 1'b1);
    check("sat_dc_est", 32'(dc_est), 32'd32767);
    drive(24'd0, 1'b1);
    idle(3);

    // backpressure: first group held, second (-207) dropped
    do_reset();
    ready = 1'b0;
    exp_q.push_back(32'd910);
    repeat (4) drive(24'd1000, 1'b1);
    repeat (4) drive(24'd0, 1'b1);
    idle(3);
    check("bp_data_held", data, 32'd910);
    check("bp_valid_held", 32'(valid), 32'd1);
    check("bp_drops", 32'(drops), 32'd1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    check("bp_valid_fall", 32'(valid), 32'd0);
    ready = 1'b1;
    idle(2);

    // candidate lands in the same cycle as a handshake
    do_reset();
    ready = 1'b0;
    exp_q.push_back(32'd0);
    repeat (4) drive(24'd0, 1'b1);
    idle(2);
    exp_q.push_back(32'd910);
    repeat (4) drive(24'd1000, 1'b1);
    ready = 1'b1;
    idle(1);
    check("sim_valid", 32'(valid), 32'd1);
    check("sim_data", data, 32'd910);
    check("sim_drops", 32'(drops), 32'd0);
    idle(2);

    // reset in the middle of a group
    do_reset();
    drive(24'd5000, 1'b1);
    drive(24'd5000, 1'b1);
    sample_valid = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    check("rstmid_dc_async", 32'(dc_est), 32'd0);
    check("rstmid_valid_async", 32'(valid), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(32'd910);
    for (int i = 0; i < 4; i++) begin
      drive(24'd1000, 1'b1);
      check($sformatf("rstmid_valid_low_%0d", i), 32'(valid), 32'd0);
    end
    idle(1);
    check("rstmid_valid_high", 32'(valid), 32'd1);
    check("rstmid_data", data, 32'd910);
    idle(3);
  endtask

  task automatic sat_seq;
    repeat (2) @(posedge clk);
    #3 rst_sat_n = 1'b1;
    @(posedge clk);
    #2 s_valid_in = 1'b1;
    repeat (65535) @(posedge clk);
    #2 s_valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("satdrop_fffe", 32'(s_drops), 32'h0000_FFFE);
    check("satdrop_valid", 32'(s_valid), 32'd1);
    s_valid_in = 1'b1;
    repeat (6) @(posedge clk);
    #2 s_valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("satdrop_ffff", 32'(s_drops), 32'h0000_FFFF);
    check("satdrop_data", s_data, 32'd0);
  endtask

  initial begin
    fork
      main_seq();
      sat_seq();
    join
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
